// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with an iterative one-bit-per-cycle shifter,
// Z/N/C/V flags and a sticky overflow flag.
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       alu_ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             negative_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             ovf_sticky_o,
    input  logic             clr_sticky_i
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;  // holds 0..WIDTH

    localparam logic [3:0] OpSub = 4'd0;
    localparam logic [3:0] OpAdd = 4'd1;
    localparam logic [3:0] OpOr  = 4'd2;
    localparam logic [3:0] OpAnd = 4'd3;
    localparam logic [3:0] OpDec = 4'd4;
    localparam logic [3:0] OpInc = 4'd5;
    localparam logic [3:0] OpInv = 4'd6;
    localparam logic [3:0] OpLsl = 4'd8;
    localparam logic [3:0] OpSlt = 4'd9;
    localparam logic [3:0] OpLsr = 4'd10;
    localparam logic [3:0] OpAsl = 4'd12;
    localparam logic [3:0] OpAsr = 4'd14;

    localparam logic [WIDTH-1:0] SMin = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SMax = ~SMin;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             sign_q, sign_d, acc_q, acc_d;

    logic             accept, out_hs, load_op;
    logic [CW-1:0]    k;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] ld_res;
    logic             ld_carry, ld_ovf, ld_shift;
    logic [WIDTH-1:0] sh_nx;
    logic             term, acc_nx, fin_ovf;

    assign in_ready_o   = !rst_i && ((state_q == StIdle) || ((state_q == StDone) && out_ready_i));
    assign accept       = in_valid_i && in_ready_o;
    assign out_hs       = (state_q == StDone) && out_ready_i;
    assign out_valid_o  = (state_q == StDone);
    assign result_o     = result_q;
    assign zero_o       = zero_q;
    assign negative_o   = neg_q;
    assign carry_o      = carry_q;
    assign overflow_o   = ovf_q;
    assign ovf_sticky_o = sticky_q;

    // Decode the op presented at the input: single-cycle result or shift setup.
    always_comb begin
        sum_w    = '0;
        ld_res   = '0;
        ld_carry = 1'b0;
        ld_ovf   = 1'b0;
        ld_shift = 1'b0;
        // Any bit at or above log2(WIDTH) set means the amount saturates at WIDTH.
        k = (|b_i[WIDTH-1:CW-1]) ? CW'(WIDTH) : {1'b0, b_i[CW-2:0]};
        case (alu_ctrl_i)
            OpSub: begin
                sum_w    = {1'b0, a_i} - {1'b0, b_i};
                ld_res   = sum_w[WIDTH-1:0];
                ld_carry = sum_w[WIDTH];
                ld_ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (ld_res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OpAdd: begin
                sum_w    = {1'b0, a_i} + {1'b0, b_i};
                ld_res   = sum_w[WIDTH-1:0];
                ld_carry = sum_w[WIDTH];
                ld_ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (ld_res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OpOr:  ld_res = a_i | b_i;
            OpAnd: ld_res = a_i & b_i;
            OpDec: begin
                ld_res   = a_i - WIDTH'(1);
                ld_ovf   = (a_i == SMin);
                ld_carry = (a_i == '0);
            end
            OpInc: begin
                ld_res   = a_i + WIDTH'(1);
                ld_ovf   = (a_i == SMax);
                ld_carry = (a_i == '1);
            end
            OpInv: ld_res = ~a_i;
            OpSlt: ld_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OpLsl, OpLsr, OpAsl, OpAsr: begin
                if (k == '0) ld_res = a_i;
                else         ld_shift = 1'b1;
            end
            default: ld_res = '0;
        endcase
    end

    // One shift step plus the overflow term it contributes.
    always_comb begin
        sh_nx = sh_q;
        term  = 1'b0;
        case (op_q)
            OpLsl: begin
                sh_nx = {sh_q[WIDTH-2:0], 1'b0};
                term  = sh_q[WIDTH-1];
            end
            OpLsr: begin
                sh_nx = {1'b0, sh_q[WIDTH-1:1]};
                term  = sh_q[0];
            end
            OpAsl: begin
                sh_nx = {sh_q[WIDTH-2:0], 1'b0};
                term  = sh_q[WIDTH-1] ^ sign_q;
            end
            OpAsr: sh_nx = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            default: sh_nx = sh_q;
        endcase
        acc_nx  = acc_q | term;
        fin_ovf = acc_nx | ((op_q == OpAsl) && (sh_nx[WIDTH-1] != sign_q));
    end

    // Next-state logic for the FSM, result registers and sticky flag.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        acc_d    = acc_q;
        load_op  = 1'b0;

        unique case (state_q)
            StIdle: load_op = accept;
            StShift: begin
                sh_d  = sh_nx;
                cnt_d = cnt_q - CW'(1);
                acc_d = acc_nx;
                if (cnt_q == CW'(1)) begin
                    result_d = sh_nx;
                    zero_d   = (sh_nx == '0);
                    neg_d    = sh_nx[WIDTH-1];
                    carry_d  = 1'b0;
                    ovf_d    = fin_ovf;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_hs) begin
                    state_d = StIdle;
                    load_op = accept;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_op) begin
            if (ld_shift) begin
                state_d = StShift;
                sh_d    = a_i;
                cnt_d   = k;
                op_d    = alu_ctrl_i;
                sign_d  = a_i[WIDTH-1];
                acc_d   = 1'b0;
            end else begin
                state_d  = StDone;
                result_d = ld_res;
                zero_d   = (ld_res == '0);
                neg_d    = ld_res[WIDTH-1];
                carry_d  = ld_carry;
                ovf_d    = ld_ovf;
            end
        end

        // Set takes priority over clear.
        sticky_d = sticky_q;
        if (clr_sticky_i)     sticky_d = 1'b0;
        if (out_hs && ovf_q)  sticky_d = 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            sh_q     <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            acc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH = 16).
module tb_alu_seq;

    localparam logic [3:0] OpSub = 4'd0, OpAdd = 4'd1, OpOr = 4'd2, OpAnd = 4'd3;
    localparam logic [3:0] OpDec = 4'd4, OpInc = 4'd5, OpInv = 4'd6, OpLsl = 4'd8;
    localparam logic [3:0] OpSlt = 4'd9, OpLsr = 4'd10, OpAsl = 4'd12, OpAsr = 4'd14;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready, clr_sticky;
    logic [15:0] a, b, result;
    logic [3:0]  alu_ctrl;
    logic        zero, negative, carry, overflow, ovf_sticky;

    int n_tests, n_fail, cyc;
    logic ready_bad, seen_valid;

    alu_seq #(.WIDTH(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .alu_ctrl_i  (alu_ctrl),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .zero_o      (zero),
        .negative_o  (negative),
        .carry_o     (carry),
        .overflow_o  (overflow),
        .ovf_sticky_o(ovf_sticky),
        .clr_sticky_i(clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one op for a single cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv);
        chk("issue_in_ready", 16'(in_ready), 16'd1);
        alu_ctrl = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Cycles from accept until out_valid, counting the accept cycle as 1.
    task automatic wait_valid(output int cycles, output logic rdy_bad);
        cycles  = 1;
        rdy_bad = 1'b0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_ctrl = '0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_result", result, 16'h0000);
        chk("rst_zero", 16'(zero), 16'd0);
        chk("rst_sticky", 16'(ovf_sticky), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 16'(in_ready), 16'd1);
        out_ready = 1'b1;

        // ADD signed overflow, then sticky set and clear.
        issue(OpAdd, 16'h7FFF, 16'h0001);
        chk("add_valid", 16'(out_valid), 16'd1);
        chk("add_result", result, 16'h8000);
        chk("add_ovf", 16'(overflow), 16'd1);
        chk("add_neg", 16'(negative), 16'd1);
        chk("add_carry", 16'(carry), 16'd0);
        chk("add_zero", 16'(zero), 16'd0);
        chk("add_sticky_pre", 16'(ovf_sticky), 16'd0);
        @(negedge clk);
        chk("add_drained", 16'(out_valid), 16'd0);
        chk("add_sticky", 16'(ovf_sticky), 16'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky_clr", 16'(ovf_sticky), 16'd0);

        // SUB back-to-back.
        issue(OpSub, 16'd5, 16'd5);
        chk("sub_eq_result", result, 16'h0000);
        chk("sub_eq_zero", 16'(zero), 16'd1);
        chk("sub_eq_carry", 16'(carry), 16'd0);
        issue(OpSub, 16'd3, 16'd5);
        chk("sub_lt_result", result, 16'hFFFE);
        chk("sub_lt_carry", 16'(carry), 16'd1);
        chk("sub_lt_ovf", 16'(overflow), 16'd0);
        chk("sub_lt_neg", 16'(negative), 16'd1);

        // ASR k=3; inputs change while in flight.
        issue(OpAsr, 16'h8000, 16'd3);
        a = 16'h0000; b = 16'h0000; alu_ctrl = OpAdd;
        wait_valid(cyc, ready_bad);
        chk("asr_latency", 16'(cyc), 16'd4);
        chk("asr_in_ready_low", 16'(ready_bad), 16'd0);
        chk("asr_result", result, 16'hF000);
        chk("asr_ovf", 16'(overflow), 16'd0);

        // LSL k=1 drops a 1.
        issue(OpLsl, 16'h8001, 16'd1);
        wait_valid(cyc, ready_bad);
        chk("lsl_latency", 16'(cyc), 16'd2);
        chk("lsl_result", result, 16'h0002);
        chk("lsl_ovf", 16'(overflow), 16'd1);
        @(negedge clk);
        chk("lsl_sticky", 16'(ovf_sticky), 16'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;

        // LSR with saturated amount.
        issue(OpLsr, 16'h1234, 16'd20);
        wait_valid(cyc, ready_bad);
        chk("lsr_latency", 16'(cyc), 16'd17);
        chk("lsr_result", result, 16'h0000);
        chk("lsr_zero", 16'(zero), 16'd1);
        chk("lsr_ovf", 16'(overflow), 16'd1);

        // Logic, compare and inc/dec corners.
        issue(OpOr, 16'hF0F0, 16'h0F00);
        chk("or_result", result, 16'hFFF0);
        issue(OpAnd, 16'hF0F0, 16'h0FF0);
        chk("and_result", result, 16'h00F0);
        issue(OpInv, 16'h00FF, 16'h0000);
        chk("inv_result", result, 16'hFF00);
        issue(OpSlt, 16'hFFFF, 16'h0001);
        chk("slt_true", result, 16'h0001);
        issue(OpSlt, 16'h0001, 16'hFFFF);
        chk("slt_false", result, 16'h0000);
        issue(OpDec, 16'h0000, 16'h0000);
        chk("dec0_result", result, 16'hFFFF);
        chk("dec0_carry", 16'(carry), 16'd1);
        chk("dec0_ovf", 16'(overflow), 16'd0);
        issue(OpDec, 16'h8000, 16'h0000);
        chk("decmin_result", result, 16'h7FFF);
        chk("decmin_ovf", 16'(overflow), 16'd1);
        chk("decmin_carry", 16'(carry), 16'd0);
        issue(OpInc, 16'hFFFF, 16'h0000);
        chk("incff_result", result, 16'h0000);
        chk("incff_carry", 16'(carry), 16'd1);
        chk("incff_zero", 16'(zero), 16'd1);
        issue(OpAdd, 16'hFFFF, 16'h0001);
        chk("addc_carry", 16'(carry), 16'd1);
        chk("addc_ovf", 16'(overflow), 16'd0);
        issue(OpAsl, 16'h4000, 16'd1);
        wait_valid(cyc, ready_bad);
        chk("asl_latency", 16'(cyc), 16'd2);
        chk("asl_result", result, 16'h8000);
        chk("asl_ovf", 16'(overflow), 16'd1);
        issue(OpAsl, 16'hC000, 16'd0);
        chk("asl0_valid", 16'(out_valid), 16'd1);
        chk("asl0_result", result, 16'hC000);
        chk("asl0_ovf", 16'(overflow), 16'd0);

        // Clear, then clear colliding with a set.
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky_clr2", 16'(ovf_sticky), 16'd0);
        issue(OpInc, 16'h7FFF, 16'h0000);
        chk("incmax_ovf", 16'(overflow), 16'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        chk("sticky_set_wins", 16'(ovf_sticky), 16'd1);
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky_clr3", 16'(ovf_sticky), 16'd0);

        // Backpressure.
        out_ready = 1'b0;
        alu_ctrl  = OpInc;
        a         = 16'h0001;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("bp_first_valid", 16'(out_valid), 16'd1);
        chk("bp_first_result", result, 16'h0002);
        a = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 16'(in_ready), 16'd0);
            @(negedge clk);
            chk("bp_hold", result, 16'h0002);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        chk("bp_second", result, 16'h0011);
        a = 16'h0020;
        @(negedge clk);
        chk("bp_third", result, 16'h0021);
        chk("bp_third_valid", 16'(out_valid), 16'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", 16'(out_valid), 16'd0);

        // Reset mid-shift.
        issue(OpLsl, 16'h0001, 16'd10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_shift_valid", 16'(out_valid), 16'd0);
        chk("rst_shift_ready", 16'(in_ready), 16'd0);
        rst = 1'b0;
        #1;
        chk("rst_shift_idle", 16'(in_ready), 16'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        chk("rst_shift_no_out", 16'(seen_valid), 16'd0);
        chk("rst_shift_result", result, 16'h0000);

        // NOP codes.
        issue(4'd7, 16'h1234, 16'h5678);
        chk("nop7_valid", 16'(out_valid), 16'd1);
        chk("nop7_result", result, 16'h0000);
        chk("nop7_zero", 16'(zero), 16'd1);
        issue(4'd15, 16'hFFFF, 16'hFFFF);
        chk("nop15_result", result, 16'h0000);
        chk("nop15_carry", 16'(carry), 16'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 16-bit combinational ALU. Keeps the same 4-bit operation encoding and adds:

- a `WIDTH` parameter;
- registered results with valid/ready handshakes on input and output;
- an iterative one-bit-per-cycle shifter, so shift latency tracks shift amount;
- Carry, Negative and sticky-overflow flags.

It sits between operand fetch and writeback in the multi-cycle datapath.

## Interface
- `WIDTH`, 16: operand/result width, ≥ 4, power of two.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `in_valid` in 1: operands and op are valid.
- `in_ready` out 1: block accepts a new op this cycle.
- `a` in `WIDTH`: operand A.
- `b` in `WIDTH`: operand B; also the shift amount for shifts.
- `alu_ctrl` in 4: operation code.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer takes the result.
- `result` out `WIDTH`: registered result.
- `zero` out 1: result == 0.
- `negative` out 1: `result[WIDTH-1]`.
- `carry` out 1: carry/borrow flag.
- `overflow` out 1: per-op overflow.
- `ovf_sticky` out 1: OR of `overflow` over all delivered results since clear.
- `clr_sticky` in 1: clears `ovf_sticky`.

## Operation
Operation codes, with the `overflow` and `carry` each sets (flags not listed are 0):

- 0 SUB, A−B: `overflow` = signed overflow; `carry` = borrow (A < B unsigned).
- 1 ADD: `overflow` = signed overflow; `carry` = carry-out.
- 2 OR, 3 AND.
- 4 DEC, A−1: `overflow` when A = signed min; `carry` (borrow) when A = 0.
- 5 INC, A+1: `overflow` when A = signed max; `carry` when A = all ones.
- 6 INV, ~A.
- 8 LSL: `overflow` if any 1 is shifted out.
- 9 SLT: signed A<B gives 1, else 0.
- 10 LSR: `overflow` if any 1 is shifted out.
- 12 ASL: `overflow` if any shifted-out bit or the final MSB differs from `a[WIDTH-1]`.
- 14 ASR: sign fill.
- 7, 11, 13, 15 NOP: result 0, all flags computed from result 0.

Shift amount:
- k = min(b unsigned, `WIDTH`).
- k = `WIDTH` gives all zeros for LSL/LSR/ASL and all sign bits for ASR.
- k = 0 passes A through with `overflow` 0.

State machine:
- IDLE: on accept, non-shift ops and shifts with k = 0 go to DONE with the result registered. Shifts with k ≥ 1 load A and cnt = k, then go to SHIFT.
- SHIFT: each cycle shifts one bit, accumulates the overflow term and decrements cnt. The cycle with cnt = 1 writes the final result and goes to DONE.
- DONE: `out_valid` = 1. `result` and flags hold stable until `out_ready`. On handshake, go to IDLE, or take a new op directly if one is accepted in the same cycle.

Handshake:
- `in_ready` = !`rst` && (state == IDLE || (state == DONE && `out_ready`)).
- Accept occurs when `in_valid` && `in_ready`.
- Inputs are sampled only at accept. Later changes to `a`/`b`/`alu_ctrl` do not affect an op in flight.

Flags:
- `ovf_sticky` sets on an output handshake whose `overflow` = 1.
- `clr_sticky` clears it. If clear and set happen in the same cycle, set wins.

## Timing
- Reset (sync): state IDLE, `out_valid` 0, `result` 0, `zero` 0, `negative` 0, `carry` 0, `overflow` 0, `ovf_sticky` 0, cnt 0. `in_ready` = 0 during reset and 1 in the first cycle after.
- `rst` mid-SHIFT or mid-DONE discards the op; no output handshake occurs.
- Latency from the accept edge to the edge after which `out_valid` = 1:
  - 1 cycle for non-shift ops and k = 0;
  - 1 + k cycles for shifts with k ≥ 1.
- Throughput: one non-shift op per cycle while `out_ready` is held high (DONE→accept→DONE back-to-back).
- With `out_ready` low, DONE holds indefinitely and `in_ready` = 0.
- All outputs are registered. No combinational path from `a`/`b`/`alu_ctrl` to outputs. Only `in_ready` depends combinationally on `out_ready`.

## Test plan
- Reset → `out_valid` 0, `result` 0, `ovf_sticky` 0; `in_ready` 1 in the next cycle.
- WIDTH = 16, ADD a = 0x7FFF, b = 0x0001, `out_ready` = 1:
  - 1 cycle later: `result` 0x8000, `overflow` 1, `negative` 1, `carry` 0, `zero` 0.
  - `ovf_sticky` 1 after the handshake.
  - `clr_sticky` then clears it.
- SUB a = 5, b = 5 → `result` 0, `zero` 1, `carry` 0. Then SUB a = 3, b = 5 → 0xFFFE, `carry` 1, `overflow` 0.
- ASR a = 0x8000, b = 3 → `out_valid` exactly 4 cycles after accept, `result` 0xF000, `in_ready` 0 meanwhile. Also:
  - LSL a = 0x8001, b = 1 → 0x0002, `overflow` 1.
  - LSR b = 20 → 0x0000 after 17 cycles.
- Backpressure: issue three INC ops with `out_ready` low → only the first is accepted, and its result holds stable. Raise `out_ready` → back-to-back results, one per cycle.
- Assert `rst` during the SHIFT of LSL b = 10 → no `out_valid`, IDLE next cycle. NOP code 7 → `result` 0, `zero` 1.
